// File: rtl/lsu_mem_ctrl_pkg.sv
// rtl/lsu_mem_ctrl_pkg.sv - RV32I load/store types, funct3 codes and state encoding for the LSU
package lsu_mem_ctrl_pkg;

   typedef enum logic [1:0] {
      BYTE = 2'b00,
      HALF = 2'b01,
      WORD = 2'b10
   } mem_size_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DONE
   } lsu_state_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   function automatic logic f3_illegal(input logic write, input logic [2:0] f3);
      if (write)
         return f3 > F3_SW;
      return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
   endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// rtl/lsu_mem_ctrl_if.sv - word-addressed data memory request/response bus
interface lsu_mem_ctrl_if;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_rsp_valid;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
      input  mem_req_ready, mem_rsp_valid, mem_rdata
   );

   modport slave (
      input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
      output mem_req_ready, mem_rsp_valid, mem_rdata
   );
endinterface

// File: rtl/lsu_mem_ctrl_load_extend.sv
// rtl/lsu_mem_ctrl_load_extend.sv - selects the addressed byte/half of a read word and extends it
module load_extend
   import lsu_mem_ctrl_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_addr,
   input  logic [2:0]  i_funct3,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      case (i_addr)
         2'b00:   w_byte = i_rdata[7:0];
         2'b01:   w_byte = i_rdata[15:8];
         2'b10:   w_byte = i_rdata[23:16];
         default: w_byte = i_rdata[31:24];
      endcase
      // addr[0] is deliberately ignored for halves so unaligned halves fold onto their word half
      w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
      case (i_funct3)
         F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
         F3_LH:   o_data = {{16{w_half[15]}}, w_half};
         F3_LBU:  o_data = {24'h0, w_byte};
         F3_LHU:  o_data = {16'h0, w_half};
         default: o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - multi-cycle RV32I load/store unit with stall and timeout
// Optional misaligned-access trap: LSU_MISALIGN_TRAP_EN
module lsu_mem_ctrl
   import lsu_mem_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_WIDTH      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_req_valid,
   input  logic                  i_req_write,
   input  logic [2:0]            i_req_funct3,
   input  logic [31:0]           i_req_addr,
   input  logic [31:0]           i_req_wdata,
   output logic                  o_stall,
   output logic [31:0]           o_load_data,
   output logic                  o_load_valid,
   output logic                  o_bus_error,
   output logic                  o_misaligned,
   lsu_mem_ctrl_if.master        mem
);

   lsu_state_t           r_state;
   lsu_state_t           w_next;
   logic                 r_write;
   logic [2:0]           r_funct3;
   logic [31:0]          r_addr;
   logic [31:0]          r_wdata;
   logic [31:0]          r_load_data;
   logic                 r_err;
   logic                 r_mis;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic                 w_illegal;
   logic                 w_misalign;
   logic                 w_timeout;
   logic                 w_store_acc;
   logic                 w_abort;
   logic [3:0]           w_lanes;
   logic [31:0]          w_wdata_rep;
   logic [31:0]          w_ext;

   assign w_illegal = f3_illegal(i_req_write, i_req_funct3);

`ifdef LSU_MISALIGN_TRAP_EN
   assign w_misalign = !w_illegal &&
      ((mem_size_t'(i_req_funct3[1:0]) == HALF && i_req_addr[0]) ||
       (mem_size_t'(i_req_funct3[1:0]) == WORD && i_req_addr[1:0] != 2'b00));
   assign o_misaligned = (r_state == S_DONE) && r_mis;
`else
   assign w_misalign   = 1'b0;
   assign o_misaligned = 1'b0;
`endif

   generate
      if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
         assign w_timeout = 1'b0;
      end else begin : g_timeout
         assign w_timeout = (r_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
      end
   endgenerate

   // The last budgeted cycle only succeeds if it finishes the access; a load accepted then still aborts
   assign w_store_acc = mem.mem_req_ready && r_write;
   assign w_abort     = w_timeout &&
      ((r_state == S_REQ && !w_store_acc) || (r_state == S_WAIT && !mem.mem_rsp_valid));

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_req_valid)
               w_next = (w_illegal || w_misalign) ? S_DONE : S_REQ;
         end
         S_REQ: begin
            if (w_store_acc || w_abort)
               w_next = S_DONE;
            else if (mem.mem_req_ready)
               w_next = S_WAIT;
         end
         S_WAIT: begin
            if (mem.mem_rsp_valid || w_abort)
               w_next = S_DONE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_write     <= 1'b0;
         r_funct3    <= 3'b000;
         r_addr      <= 32'h0;
         r_wdata     <= 32'h0;
         r_load_data <= 32'h0;
         r_err       <= 1'b0;
         r_mis       <= 1'b0;
         r_cnt       <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_req_valid) begin
                  r_write  <= i_req_write;
                  r_funct3 <= i_req_funct3;
                  r_addr   <= i_req_addr;
                  r_wdata  <= i_req_wdata;
                  r_err    <= 1'b0;
                  r_mis    <= w_misalign;
                  r_cnt    <= '0;
                  if (w_illegal || w_misalign)
                     r_load_data <= 32'h0;
               end
            end
            S_REQ, S_WAIT: begin
               r_cnt <= r_cnt + 1'b1;
               if (w_abort) begin
                  r_err       <= 1'b1;
                  r_load_data <= 32'h0;
               end else if (r_state == S_WAIT && mem.mem_rsp_valid) begin
                  r_load_data <= w_ext;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_lanes     = 4'b1111;
      w_wdata_rep = r_wdata;
      case (mem_size_t'(r_funct3[1:0]))
         BYTE: begin
            w_lanes     = 4'b0001 << r_addr[1:0];
            w_wdata_rep = {4{r_wdata[7:0]}};
         end
         HALF: begin
            w_lanes     = 4'b0011 << {r_addr[1], 1'b0};
            w_wdata_rep = {2{r_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   load_extend u_load_extend (
      .i_rdata  (mem.mem_rdata),
      .i_addr   (r_addr[1:0]),
      .i_funct3 (r_funct3),
      .o_data   (w_ext)
   );

   assign mem.mem_req_valid = (r_state == S_REQ);
   assign mem.mem_we        = r_write;
   assign mem.mem_addr      = {r_addr[31:2], 2'b00};
   assign mem.mem_wdata     = w_wdata_rep;
   assign mem.mem_wstrb     = r_write ? w_lanes : 4'b0000;

   assign o_stall      = i_req_valid && (r_state != S_DONE);
   assign o_load_data  = r_load_data;
   assign o_load_valid = (r_state == S_DONE) && !r_write && !r_err && !r_mis;
   assign o_bus_error  = (r_state == S_DONE) && r_err;

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit directly downstream of the single-cycle RV32I datapath.
- Takes the datapath's ALU-computed address, store data and funct3, and runs a multi-cycle handshake to a word-addressed data memory.
- Returns sign- or zero-extended load data, and holds the datapath with a stall until the access completes.
- Lets the core use memories with variable latency instead of a zero-latency combinational RAM.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles waiting in REQ or WAIT before abort with bus_error; 0 disables timeout.
- CNT_WIDTH, 8, width of the timeout counter; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  datapath is executing a load or store this cycle
- req_write  in  1  1=store, 0=load
- req_funct3  in  3  RV32I load/store funct3
- req_addr  in  32  byte address (ALU result)
- req_wdata  in  32  store data (rs2)
- stall  out  1  hold PC and register write-back
- load_data  out  32  extended load result, valid while load_valid=1
- load_valid  out  1  one-cycle pulse, load complete
- bus_error  out  1  one-cycle pulse, timeout abort
- misaligned  out  1  one-cycle pulse, misaligned access (feature only; tied 0 otherwise)
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_we  out  1  write request
- mem_addr  out  32  word-aligned address, bits [1:0]=0
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte strobes (0 for reads)
- mem_rsp_valid  in  1  read data valid
- mem_rdata  in  32  read word

Behaviour:
- Reset values: state IDLE; all outputs 0; timeout counter 0.
- FSM states: IDLE, REQ, WAIT, DONE.
- stall = req_valid && state!=DONE (combinational), so the datapath advances only on the DONE cycle.
- IDLE:
  - On req_valid, latch write, funct3, addr and wdata; go to REQ.
  - Illegal funct3 (loads: 011, 110, 111; stores: funct3>010) skips the bus: go DONE, load_data=0.
- REQ:
  - mem_req_valid=1; mem_addr, mem_we, mem_wstrb and mem_wdata stay stable until mem_req_ready.
  - Store accepted: go DONE.
  - Load accepted: go WAIT.
- WAIT:
  - mem_rsp_valid is sampled only in this state; a response in the same cycle as acceptance is not legal.
  - On mem_rsp_valid, register the extended data and go DONE.
- DONE:
  - Lasts one cycle; load_valid=1 for loads; go IDLE.
  - A new req_valid is seen in IDLE on the following cycle.
- Minimum latency:
  - Store: 3 cycles (IDLE, REQ with ready, DONE).
  - Load: 4 cycles (IDLE, REQ, WAIT, DONE).
- Store lanes:
  - SB: wstrb=0001<<addr[1:0]; wdata = byte replicated x4.
  - SH: wstrb=0011<<{addr[1],1'b0}; wdata = half replicated x2.
  - SW: wstrb=1111.
- Load extract: byte/half selected by latched addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Timeout:
  - Counter clears on entering REQ and counts every cycle in REQ or WAIT.
  - On reaching TIMEOUT_CYCLES: drop mem_req_valid, go DONE with bus_error=1, load_data=0.
- Reset mid-operation: next state IDLE, mem_req_valid=0. A late mem_rsp_valid arriving in IDLE is ignored.
- load_data holds its last value outside DONE.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned access is detected in IDLE: half with addr[0]=1, word with addr[1:0]!=0.
  - No bus access is made; go DONE with misaligned=1 and load_data=0; stores are dropped.
- Undefined:
  - Misaligned bits are masked: half uses addr[1] only, word ignores addr[1:0].
  - The access is performed normally; misaligned is tied 0.

Decomposition:
- Add to rv32i_defs:
  - mem_size_t enum: BYTE=2'b00, HALF=2'b01, WORD=2'b10.
  - lsu_state_t enum for the FSM states.
  - funct3 constants F3_LB/LH/LW/LBU/LHU/SB/SH/SW.
- One combinational sub-module, load_extend: inputs rdata, addr[1:0], funct3; output the extended 32-bit word.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, ready=1 immediately -> mem_addr=0x100, wstrb=1111, stall high 2 cycles, low in DONE.
- SB addr=0x103, wdata=0x000000A5 -> wstrb=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x100.
- LB addr=0x102, rdata=0x0080FF00, rsp 3 cycles after accept -> load_data=0xFFFFFF80, load_valid one pulse. LBU at the same address -> 0x00000080.
- LH addr=0x102, rdata=0x8001_0000 -> 0xFFFF8001. LHU -> 0x00008001.
- mem_req_ready held 0, TIMEOUT_CYCLES=4 -> bus_error pulse on the 5th cycle after IDLE, load_data=0, state IDLE afterwards. rst asserted in WAIT -> IDLE next cycle, later mem_rsp_valid ignored.
- LW addr=0x101:
  - With LSU_MISALIGN_TRAP_EN: misaligned=1, no mem_req_valid.
  - Without it: mem_addr=0x100, load_data=rdata.
